// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator. A clock divider produces a pixel
// clock-enable; horizontal and vertical counters walk the raster and the
// sync, in_screen and event pulses decode from them combinationally.
// Optional feature: define VGA_SYNC_GEN_FRAME_CTR_EN to add a 16-bit
// wrapping frame counter output (frame_cnt).
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clock_100Mhz,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [HW-1:0] horctr,
    output logic [VW-1:0] verctr,
    output logic          horzsync,
    output logic          vertsync,
    output logic          in_screen,
    output logic          line_end,
    output logic          frame_end,
    output logic          vblank_start
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    // Divider width; a 1-bit divider that never leaves 0 covers CLK_DIV=1.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);

    // Sync windows compared one bit wider so an end bound equal to the
    // total (zero back porch) still fits.
    localparam logic [HW:0] H_SS = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] H_SE = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_SS = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] V_SE = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hor_q, hor_d;
    logic [VW-1:0] ver_q, ver_d;

    logic ce_raw;
    logic line_end_raw;
    logic frame_end_raw;
    logic vblank_raw;
    logic hs_active;
    logic vs_active;
    logic in_area;

    // Event decode from the counter registers (ungated by reset).
    always_comb begin
        ce_raw        = en && (div_q == DIV_LAST);
        line_end_raw  = ce_raw && (hor_q == H_LAST);
        frame_end_raw = line_end_raw && (ver_q == V_LAST);
        vblank_raw    = line_end_raw && (ver_q == V_ACT_LAST);
        hs_active     = ({1'b0, hor_q} >= H_SS) && ({1'b0, hor_q} < H_SE);
        vs_active     = ({1'b0, ver_q} >= V_SS) && ({1'b0, ver_q} < V_SE);
        in_area       = (hor_q < H_ACT) && (ver_q < V_ACT);
    end

    // Next-state for divider and raster counters; everything holds when en=0.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        div_d = div_q;
        hor_d = hor_q;
        ver_d = ver_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        if (ce_raw) begin
            if (hor_q == H_LAST) begin
                hor_d = '0;
                ver_d = (ver_q == V_LAST) ? '0 : ver_q + VW'(1);
            end else begin
                hor_d = hor_q + HW'(1);
            end
        end
    end

    // Counter registers with synchronous reset that overrides en.
    always_ff @(posedge clock_100Mhz) begin
        // NOTE: non-blocking assignments so all registers update together
        // from values sampled before the edge.
        if (rst) begin
            div_q <= '0;
            hor_q <= '0;
            ver_q <= '0;
        end else begin
            div_q <= div_d;
            hor_q <= hor_d;
            ver_q <= ver_d;
        end
    end

    // Outputs forced to their idle values for the whole time rst is high.
    always_comb begin
        pix_ce       = !rst && ce_raw;
        line_end     = !rst && line_end_raw;
        frame_end    = !rst && frame_end_raw;
        vblank_start = !rst && vblank_raw;
        horctr       = rst ? '0 : hor_q;
        verctr       = rst ? '0 : ver_q;
        in_screen    = !rst && in_area;
        horzsync     = (!rst && hs_active) ? H_POL : !H_POL;
        vertsync     = (!rst && vs_active) ? V_POL : !V_POL;
    end

`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter next value; wraps naturally from 0xFFFF to 0.
    always_comb begin
        frame_cnt_d = frame_end_raw ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Frame counter register.
    always_ff @(posedge clock_100Mhz) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Frame counter output, zero while in reset.
    always_comb begin
        frame_cnt = rst ? 16'd0 : frame_cnt_q;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives two differently configured vga_sync_gen instances
// with the same rst/en stimulus. The expected outputs come from a raster
// model that tracks only a divider phase and a linear pixel count, deriving
// counters and decodes with division/modulo arithmetic.
module tb_vga_sync_gen;

    // Configuration of the two instances: [0] divided clock, high hsync,
    // low vsync; [1] undivided clock, low hsync, high vsync.
    localparam int CD [2] = '{3, 1};
    localparam int HA [2] = '{8, 6};
    localparam int HF [2] = '{2, 1};
    localparam int HS [2] = '{3, 2};
    localparam int HB [2] = '{2, 3};
    localparam int VA [2] = '{5, 4};
    localparam int VF [2] = '{1, 2};
    localparam int VS [2] = '{2, 1};
    localparam int VB [2] = '{1, 1};
    localparam int HP [2] = '{1, 0};
    localparam int VP [2] = '{0, 1};

    typedef struct {
        integer ce, hor, ver, hs, vs, ins, le, fe, vb, fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic        d0_ce, d0_hs, d0_vs, d0_ins, d0_le, d0_fe, d0_vb;
    logic [3:0]  d0_hor, d0_ver;
    logic        d1_ce, d1_hs, d1_vs, d1_ins, d1_le, d1_fe, d1_vb;
    logic [3:0]  d1_hor;
    logic [2:0]  d1_ver;
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
    logic [15:0] d0_fc, d1_fc;
`endif

    vga_sync_gen #(
        .CLK_DIV(CD[0]), .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .H_POL(HP[0] != 0), .V_POL(VP[0] != 0)
    ) dut0 (
        .clock_100Mhz(clk), .rst(rst), .en(en), .pix_ce(d0_ce),
        .horctr(d0_hor), .verctr(d0_ver), .horzsync(d0_hs), .vertsync(d0_vs),
        .in_screen(d0_ins), .line_end(d0_le), .frame_end(d0_fe),
        .vblank_start(d0_vb)
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
        , .frame_cnt(d0_fc)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(CD[1]), .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .H_POL(HP[1] != 0), .V_POL(VP[1] != 0)
    ) dut1 (
        .clock_100Mhz(clk), .rst(rst), .en(en), .pix_ce(d1_ce),
        .horctr(d1_hor), .verctr(d1_ver), .horzsync(d1_hs), .vertsync(d1_vs),
        .in_screen(d1_ins), .line_end(d1_le), .frame_end(d1_fe),
        .vblank_start(d1_vb)
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
        , .frame_cnt(d1_fc)
`endif
    );

    // Reference model state: divider phase and pixels advanced since reset.
    int ph  [2] = '{0, 0};
    int pix [2] = '{0, 0};

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int checks = 0;
    int errors = 0;

    function automatic obs_t model_out(input int k, input bit r, input bit e);
        obs_t o;
        int ht, vt, hor, ver, hss;
        int vss;
        ht  = HA[k] + HF[k] + HS[k] + HB[k];
        vt  = VA[k] + VF[k] + VS[k] + VB[k];
        hor = pix[k] % ht;
        ver = (pix[k] / ht) % vt;
        hss = HA[k] + HF[k];
        vss = VA[k] + VF[k];
        if (r) begin
            o = '{0, 0, 0, 1 - HP[k], 1 - VP[k], 0, 0, 0, 0, 0};
        end else begin
            o.ce  = (e && ph[k] == CD[k] - 1) ? 1 : 0;
            o.hor = hor;
            o.ver = ver;
            o.hs  = (hor >= hss && hor < hss + HS[k]) ? HP[k] : 1 - HP[k];
            o.vs  = (ver >= vss && ver < vss + VS[k]) ? VP[k] : 1 - VP[k];
            o.ins = (hor < HA[k] && ver < VA[k]) ? 1 : 0;
            o.le  = (o.ce == 1 && hor == ht - 1) ? 1 : 0;
            o.fe  = (o.le == 1 && ver == vt - 1) ? 1 : 0;
            o.vb  = (o.le == 1 && ver == VA[k] - 1) ? 1 : 0;
            o.fc  = (pix[k] / (ht * vt)) % 65536;
        end
        return o;
    endfunction

    task automatic model_step(input int k, input bit r, input bit e);
        if (r) begin
            ph[k]  = 0;
            pix[k] = 0;
        end else if (e) begin
            if (ph[k] == CD[k] - 1) begin
                ph[k]  = 0;
                pix[k] = pix[k] + 1;
            end else begin
                ph[k] = ph[k] + 1;
            end
        end
    endtask

    // One clock of stimulus: drive inputs just after the edge, queue the
    // expected response, then advance the model past the next edge.
    task automatic cycle(input bit r, input bit e);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        exp_q0.push_back(model_out(0, r, e));
        exp_q1.push_back(model_out(1, r, e));
        model_step(0, r, e);
        model_step(1, r, e);
    endtask

    task automatic check(input string name, input int k, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic compare(input int k, input obs_t a, input obs_t x);
        check("pix_ce", k, a.ce, x.ce);
        check("horctr", k, a.hor, x.hor);
        check("verctr", k, a.ver, x.ver);
        check("horzsync", k, a.hs, x.hs);
        check("vertsync", k, a.vs, x.vs);
        check("in_screen", k, a.ins, x.ins);
        check("line_end", k, a.le, x.le);
        check("frame_end", k, a.fe, x.fe);
        check("vblank_start", k, a.vb, x.vb);
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
        check("frame_cnt", k, a.fc, x.fc);
`endif
    endtask

    // Monitor: on each falling edge pop any pending expectation and compare
    // it with what the DUT is presenting.
    initial begin
        obs_t a, x;
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                x = exp_q0.pop_front();
                a = '{d0_ce, d0_hor, d0_ver, d0_hs, d0_vs, d0_ins, d0_le, d0_fe, d0_vb, 0};
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
                a.fc = d0_fc;
`endif
                compare(0, a, x);
            end
            if (exp_q1.size() > 0) begin
                x = exp_q1.pop_front();
                a = '{d1_ce, d1_hor, d1_ver, d1_hs, d1_vs, d1_ins, d1_le, d1_fe, d1_vb, 0};
`ifdef VGA_SYNC_GEN_FRAME_CTR_EN
                a.fc = d1_fc;
`endif
                compare(1, a, x);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        // Reset, including reset overriding en.
        repeat (5) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b1);

        // Two full frames of the slower instance with en held high.
        repeat (2 * 405 + 20) cycle(1'b0, 1'b1);

        // Drop en mid-line, part way through a divider period.
        for (int i = 0; i < 2000 && !((pix[0] % 15) == 4 && ph[0] == 1); i++)
            cycle(1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0);
        repeat (100) cycle(1'b0, 1'b1);

        // One-clock reset mid-frame on a cycle that would otherwise advance.
        for (int i = 0; i < 2000 && !((pix[0] % 15) == 6 && ((pix[0] / 15) % 9) == 3 && ph[0] == 2); i++)
            cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (450) cycle(1'b0, 1'b1);

        // Random en with occasional reset pulses.
        repeat (4000) cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
